// File: rtl/stream_mem_pkg.sv
// stream_burst_memory shared types.
// Read FSM states and output buffer sizing.
package stream_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM
  } rd_state_e;

  localparam int OBUF_DEPTH = 2;

endpackage

// File: rtl/stream_mem_ram.sv
// Simple dual-port byte-enable RAM.
// Read-first, one-cycle registered read.
module stream_mem_ram #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   waddr_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    re_i,
  input  logic [ADDR_WIDTH-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Non-blocking write keeps a same-edge read on the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < NB; i++) begin
        if (be_i[i]) begin
          mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stream_burst_memory.sv
// AXI-Stream scratch buffer: packet writes in,
// length-programmed bursts out with backpressure.
module stream_burst_memory
  import stream_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    axis_aclk,
  input  logic                    axis_reset,
  input  logic [ADDR_WIDTH-1:0]   s_axis_wr_addr,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic                    wr_done,
  input  logic                    rd_start,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [LEN_WIDTH-1:0]    rd_len,
  output logic                    rd_busy,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready
);

  localparam int NB = DATA_WIDTH / 8;

  logic                  wr_acc;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic                  first_q;
  logic                  wr_done_q;

  assign s_axis_tready = ~axis_reset;
  assign wr_acc        = s_axis_tvalid & s_axis_tready;
  assign wr_addr       = first_q ? s_axis_wr_addr : wr_ptr_q;
  assign wr_done       = wr_done_q;

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      first_q   <= 1'b1;
      wr_ptr_q  <= '0;
      wr_done_q <= 1'b0;
    end else begin
      wr_done_q <= wr_acc & s_axis_tlast;
      if (wr_acc) begin
        wr_ptr_q <= wr_addr + ADDR_WIDTH'(1);
        first_q  <= s_axis_tlast;
      end
    end
  end

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN_WIDTH-1:0]  rd_rem_q, rd_rem_d;
  logic                  rd_issue;
  logic                  pend_q;
  logic                  pend_last_q;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic [1:0]            ob_cnt_q, ob_cnt_d;
  logic [DATA_WIDTH-1:0] ob_data_q [OBUF_DEPTH];
  logic                  ob_last_q [OBUF_DEPTH];
  logic                  pop;
  logic                  push;
  logic                  push_to0;
  logic                  room;

  stream_mem_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk_i   (axis_aclk),
    .we_i    (wr_acc),
    .waddr_i (wr_addr),
    .be_i    (s_axis_tstrb),
    .wdata_i (s_axis_tdata),
    .re_i    (rd_issue),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign pop      = (ob_cnt_q != 2'd0) & m_axis_tready;
  assign push     = pend_q;
  assign push_to0 = (ob_cnt_q == 2'd0) |
                    ((ob_cnt_q == 2'd1) & pop);
  assign ob_cnt_d = ob_cnt_q + 2'(push) - 2'(pop);

  // Reads in flight plus buffered beats never exceed the buffer.
  assign room = (int'(ob_cnt_q) + int'(pend_q) - int'(pop))
                < OBUF_DEPTH;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    rd_rem_d = rd_rem_q;
    rd_issue = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_start) begin
          rd_ptr_d = rd_addr;
          rd_rem_d = rd_len;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (room) begin
          rd_issue = 1'b1;
          rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
          if (rd_rem_q == '0) begin
            state_d = STREAM;
          end else begin
            rd_rem_d = rd_rem_q - LEN_WIDTH'(1);
          end
        end
      end
      STREAM: begin
        if (pop && ob_last_q[0]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      rd_rem_q    <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_rem_q    <= rd_rem_d;
      pend_q      <= rd_issue;
      pend_last_q <= rd_issue & (rd_rem_q == '0);
    end
  end

  // Head slot only moves on a pop, so outputs hold during stalls.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      ob_cnt_q <= 2'd0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        ob_data_q[i] <= '0;
        ob_last_q[i] <= 1'b0;
      end
    end else begin
      ob_cnt_q <= ob_cnt_d;
      if (pop) begin
        ob_data_q[0] <= ob_data_q[1];
        ob_last_q[0] <= ob_last_q[1];
      end
      if (push) begin
        if (push_to0) begin
          ob_data_q[0] <= ram_rdata;
          ob_last_q[0] <= pend_last_q;
        end else begin
          ob_data_q[1] <= ram_rdata;
          ob_last_q[1] <= pend_last_q;
        end
      end
    end
  end

  assign rd_busy       = (state_q != IDLE);
  assign m_axis_tvalid = (ob_cnt_q != 2'd0);
  assign m_axis_tdata  = m_axis_tvalid ? ob_data_q[0] : '0;
  assign m_axis_tlast  = m_axis_tvalid & ob_last_q[0];
  assign m_axis_tstrb  = {NB{m_axis_tvalid}};

endmodule

// File: tb/tb_stream_burst_memory.sv
// Directed bench for stream_burst_memory.
// Expected words are hand-computed per test.
module tb_stream_burst_memory;

  logic        axis_aclk = 1'b0;
  logic        axis_reset;
  logic [11:0] s_axis_wr_addr;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tstrb;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic        wr_done;
  logic        rd_start;
  logic [11:0] rd_addr;
  logic [7:0]  rd_len;
  logic        rd_busy;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tstrb;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] exp_q [16];
  logic [31:0] col_data;

  always #5 axis_aclk = ~axis_aclk;

  stream_burst_memory dut (
    .axis_aclk      (axis_aclk),
    .axis_reset     (axis_reset),
    .s_axis_wr_addr (s_axis_wr_addr),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tstrb   (s_axis_tstrb),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .wr_done        (wr_done),
    .rd_start       (rd_start),
    .rd_addr        (rd_addr),
    .rd_len         (rd_len),
    .rd_busy        (rd_busy),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tstrb   (m_axis_tstrb),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge axis_aclk);
    #1;
  endtask

  task automatic wr_beat(input logic [11:0] a,
                         input logic [31:0] d,
                         input logic [3:0]  s,
                         input logic        l);
    s_axis_wr_addr = a;
    s_axis_tdata   = d;
    s_axis_tstrb   = s;
    s_axis_tlast   = l;
    s_axis_tvalid  = 1'b1;
    tick();
    s_axis_tvalid  = 1'b0;
    s_axis_tlast   = 1'b0;
  endtask

  // bp: stall pattern; colw: same-address write on the first read edge
  task automatic rd_burst(input logic [11:0] a,
                          input logic [7:0]  l,
                          input bit          bp,
                          input bit          colw);
    int   idx;
    int   first;
    int   lastc;
    bit   hv;
    logic [31:0] hd;
    logic hl;
    logic rdy;
    idx   = 0;
    first = -1;
    lastc = -1;
    hv    = 1'b0;
    hd    = '0;
    hl    = 1'b0;
    rd_addr  = a;
    rd_len   = l;
    rd_start = 1'b1;
    tick();
    for (int k = 0; k < 80 && idx <= int'(l); k++) begin
      if (k == 0) begin
        chk("busy_set", 32'(rd_busy), 32'd1);
        rd_start       = 1'b1;
        rd_addr        = ~a;
        s_axis_tvalid  = colw;
        s_axis_wr_addr = a;
        s_axis_tdata   = col_data;
        s_axis_tstrb   = 4'hF;
        s_axis_tlast   = 1'b1;
      end else begin
        rd_start      = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      if (hv) begin
        chk("hold_valid", 32'(m_axis_tvalid), 32'd1);
        chk("hold_data", m_axis_tdata, hd);
        chk("hold_last", 32'(m_axis_tlast), 32'(hl));
      end
      if (m_axis_tvalid && first < 0) first = k;
      rdy = bp ? (k % 5 == 0 || k % 5 == 3) : 1'b1;
      m_axis_tready = rdy;
      if (m_axis_tvalid && rdy) begin
        chk("beat_data", m_axis_tdata, exp_q[idx]);
        chk("beat_last", 32'(m_axis_tlast), 32'(idx == int'(l)));
        chk("beat_strb", 32'(m_axis_tstrb), 32'hF);
        lastc = k;
        idx++;
        hv = 1'b0;
      end else if (m_axis_tvalid) begin
        hv = 1'b1;
        hd = m_axis_tdata;
        hl = m_axis_tlast;
      end
      tick();
    end
    rd_start      = 1'b0;
    m_axis_tready = 1'b0;
    chk("beat_count", 32'(idx), 32'(int'(l) + 1));
    chk("busy_clr", 32'(rd_busy), 32'd0);
    if (!bp) begin
      chk("first_lat", 32'(first), 32'd2);
      chk("last_lat", 32'(lastc), 32'(2 + int'(l)));
    end
    repeat (3) tick();
    chk("no_queue_valid", 32'(m_axis_tvalid), 32'd0);
    chk("no_queue_busy", 32'(rd_busy), 32'd0);
  endtask

  initial begin
    axis_reset     = 1'b1;
    s_axis_wr_addr = '0;
    s_axis_tdata   = '0;
    s_axis_tstrb   = '0;
    s_axis_tvalid  = 1'b0;
    s_axis_tlast   = 1'b0;
    rd_start       = 1'b0;
    rd_addr        = '0;
    rd_len         = '0;
    m_axis_tready  = 1'b0;
    col_data       = '0;

    repeat (3) tick();
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_wr_done", 32'(wr_done), 32'd0);
    chk("rst_busy", 32'(rd_busy), 32'd0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_tstrb", 32'(m_axis_tstrb), 32'd0);
    axis_reset = 1'b0;
    tick();
    chk("tready_up", 32'(s_axis_tready), 32'd1);

    // 4-beat packet, then burst back
    wr_beat(12'h010, 32'h11111111, 4'hF, 1'b0);
    chk("wr_done_mid", 32'(wr_done), 32'd0);
    wr_beat(12'h7A0, 32'h22222222, 4'hF, 1'b0);
    wr_beat(12'h7A0, 32'h33333333, 4'hF, 1'b0);
    wr_beat(12'h7A0, 32'h44444444, 4'hF, 1'b1);
    chk("wr_done_pulse", 32'(wr_done), 32'd1);
    tick();
    chk("wr_done_drop", 32'(wr_done), 32'd0);
    exp_q[0] = 32'h11111111;
    exp_q[1] = 32'h22222222;
    exp_q[2] = 32'h33333333;
    exp_q[3] = 32'h44444444;
    rd_burst(12'h010, 8'd3, 1'b0, 1'b0);

    // byte strobes
    wr_beat(12'h020, 32'hAABBCCDD, 4'hF, 1'b1);
    wr_beat(12'h020, 32'h11223344, 4'h5, 1'b1);
    exp_q[0] = 32'hAA22CC44;
    rd_burst(12'h020, 8'd0, 1'b0, 1'b0);

    // address wrap
    wr_beat(12'hFFF, 32'hA0000001, 4'hF, 1'b0);
    wr_beat(12'h555, 32'hA0000002, 4'hF, 1'b0);
    wr_beat(12'h555, 32'hA0000003, 4'hF, 1'b1);
    exp_q[0] = 32'hA0000001;
    exp_q[1] = 32'hA0000002;
    exp_q[2] = 32'hA0000003;
    rd_burst(12'hFFF, 8'd2, 1'b0, 1'b0);
    exp_q[0] = 32'hA0000002;
    exp_q[1] = 32'hA0000003;
    rd_burst(12'h000, 8'd1, 1'b0, 1'b0);

    // backpressure over 8 beats
    for (int i = 0; i < 8; i++) begin
      wr_beat(12'h100, 32'hB0000000 + 32'(i), 4'hF, 1'(i == 7));
      exp_q[i] = 32'hB0000000 + 32'(i);
    end
    rd_burst(12'h100, 8'd7, 1'b1, 1'b0);

    // same-edge write/read returns the old word
    wr_beat(12'h030, 32'h0BAD0001, 4'hF, 1'b1);
    col_data = 32'h600D0002;
    exp_q[0] = 32'h0BAD0001;
    rd_burst(12'h030, 8'd0, 1'b0, 1'b1);
    exp_q[0] = 32'h600D0002;
    rd_burst(12'h030, 8'd0, 1'b0, 1'b0);

    // write one edge before the read issues: new word
    s_axis_wr_addr = 12'h030;
    s_axis_tdata   = 32'h600D0003;
    s_axis_tstrb   = 4'hF;
    s_axis_tlast   = 1'b1;
    s_axis_tvalid  = 1'b1;
    exp_q[0] = 32'h600D0003;
    rd_burst(12'h030, 8'd0, 1'b0, 1'b0);

    // reset mid-burst and mid-packet
    for (int i = 0; i < 6; i++) begin
      wr_beat(12'h200, 32'hC0000000 + 32'(i), 4'hF, 1'(i == 5));
    end
    wr_beat(12'h300, 32'hEE000000, 4'hF, 1'b0);
    wr_beat(12'h300, 32'hEE000001, 4'hF, 1'b0);
    rd_addr       = 12'h200;
    rd_len        = 8'd5;
    rd_start      = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (4) tick();
    chk("pre_rst_beat", m_axis_tdata, 32'hC0000002);
    axis_reset = 1'b1;
    tick();
    chk("rst_mid_valid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_mid_busy", 32'(rd_busy), 32'd0);
    chk("rst_mid_tready", 32'(s_axis_tready), 32'd0);
    axis_reset    = 1'b0;
    m_axis_tready = 1'b0;
    tick();
    wr_beat(12'h310, 32'h0D0E0F10, 4'hF, 1'b1);
    for (int i = 0; i < 6; i++) exp_q[i] = 32'hC0000000 + 32'(i);
    rd_burst(12'h200, 8'd5, 1'b0, 1'b0);
    exp_q[0] = 32'h0D0E0F10;
    rd_burst(12'h310, 8'd0, 1'b0, 1'b0);
    exp_q[0] = 32'h11111111;
    exp_q[1] = 32'h22222222;
    exp_q[2] = 32'h33333333;
    exp_q[3] = 32'h44444444;
    rd_burst(12'h010, 8'd3, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
